// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_pkg
// Purpose  : Shared state encoding and entry layout for the retire-trace buffer
// Revision : 1.0
// ============================================================================
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_t;

    localparam int c_inst_w    = 32;
    localparam int c_reg_w     = 5;
    localparam int c_off_cycle = 0;

    // Entry packing from LSB upward: cycle, rd_data, rd_addr, rd_we, inst, pc
    function automatic int entry_width(input int xlen, input int cyc_w);
        return xlen + c_inst_w + 1 + c_reg_w + xlen + cyc_w;
    endfunction

    function automatic int off_rd_data(input int cyc_w);
        return cyc_w;
    endfunction

    function automatic int off_rd_addr(input int xlen, input int cyc_w);
        return cyc_w + xlen;
    endfunction

    function automatic int off_rd_we(input int xlen, input int cyc_w);
        return cyc_w + xlen + c_reg_w;
    endfunction

    function automatic int off_inst(input int xlen, input int cyc_w);
        return cyc_w + xlen + c_reg_w + 1;
    endfunction

    function automatic int off_pc(input int xlen, input int cyc_w);
        return cyc_w + xlen + c_reg_w + 1 + c_inst_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
// Module   : trace_ram
// Purpose  : Flop-array storage, one synchronous write port, async read port
// Revision : 1.0
// ============================================================================
module trace_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : trace_capture
// Purpose  : Retire-stream trace recorder with cycle stamps, PC trigger and
//            post-trigger window, drained through a valid/ready port
// Revision : 1.0
// ============================================================================
module trace_capture
    import trace_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int CYC_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     capture_en,
    input  logic                     mode,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_inst,
    input  logic                     in_rd_we,
    input  logic [4:0]               in_rd_addr,
    input  logic [XLEN-1:0]          in_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_inst,
    output logic                     out_rd_we,
    output logic [4:0]               out_rd_addr,
    output logic [XLEN-1:0]          out_rd_data,
    output logic [CYC_W-1:0]         out_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     triggered,
    output logic                     done
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_ew = entry_width(XLEN, CYC_W);

    localparam int c_off_rd_data = off_rd_data(CYC_W);
    localparam int c_off_rd_addr = off_rd_addr(XLEN, CYC_W);
    localparam int c_off_rd_we   = off_rd_we(XLEN, CYC_W);
    localparam int c_off_inst    = off_inst(XLEN, CYC_W);
    localparam int c_off_pc      = off_pc(XLEN, CYC_W);

    trace_state_t       r_state;
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_cw-1:0]    r_count;
    logic [c_aw-1:0]    r_post_cnt;
    logic [CYC_W-1:0]   r_cycle_ctr;
    logic               r_overflow;
    logic               r_triggered;

    logic               w_capturing;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_drop;
    logic               w_write;
    logic               w_overwrite;
    logic               w_hit;
    logic               w_last_post;
    logic               w_ram_we;
    logic [c_ew-1:0]    w_wr_entry;
    logic [c_ew-1:0]    w_rd_entry;

    assign w_capturing = (r_state == ARMED) || (r_state == POST);
    assign w_push      = in_valid && w_capturing;
    assign w_pop       = (r_count != '0) && out_ready;
    assign w_full      = (r_count == c_cw'(DEPTH));
    // Stop-on-full discards the new entry only when no pop frees a slot
    assign w_drop      = w_push && w_full && !w_pop && !mode;
    assign w_write     = w_push && !w_drop;
    assign w_overwrite = w_write && w_full && !w_pop;
    assign w_hit       = w_write && (r_state == ARMED) && trig_en && (in_pc == trig_pc);
    assign w_last_post = w_write && (r_state == POST) && (r_post_cnt == c_aw'(1));
    assign w_ram_we    = w_write && !clear;

    assign w_wr_entry = {in_pc, in_inst, in_rd_we, in_rd_addr, in_rd_data, r_cycle_ctr};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_ew)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_post_cnt  <= '0;
            r_cycle_ctr <= '0;
            r_overflow  <= 1'b0;
            r_triggered <= 1'b0;
        end else begin
            r_cycle_ctr <= r_cycle_ctr + CYC_W'(1);
            if (clear) begin
                r_state     <= IDLE;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_post_cnt  <= '0;
                r_overflow  <= 1'b0;
                r_triggered <= 1'b0;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + c_aw'(1);
                end
                if (w_pop || w_overwrite) begin
                    r_rd_ptr <= r_rd_ptr + c_aw'(1);
                end

                if (w_write && !w_full && !w_pop) begin
                    r_count <= r_count + c_cw'(1);
                end else if (w_pop && !w_write) begin
                    r_count <= r_count - c_cw'(1);
                end

                if (w_drop || w_overwrite) begin
                    r_overflow <= 1'b1;
                end

                if (w_hit) begin
                    r_triggered <= 1'b1;
                    r_post_cnt  <= c_aw'(POST_TRIG);
                end else if (w_write && (r_state == POST)) begin
                    r_post_cnt <= r_post_cnt - c_aw'(1);
                end

                case (r_state)
                    IDLE: begin
                        if (capture_en) r_state <= ARMED;
                    end
                    ARMED: begin
                        if (!capture_en)  r_state <= IDLE;
                        else if (w_drop)  r_state <= DONE;
                        else if (w_hit)   r_state <= (POST_TRIG == 0) ? DONE : POST;
                    end
                    POST: begin
                        if (!capture_en)                 r_state <= IDLE;
                        else if (w_drop || w_last_post)  r_state <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid   = (r_count != '0);
    assign out_pc      = w_rd_entry[c_off_pc      +: XLEN];
    assign out_inst    = w_rd_entry[c_off_inst    +: c_inst_w];
    assign out_rd_we   = w_rd_entry[c_off_rd_we];
    assign out_rd_addr = w_rd_entry[c_off_rd_addr +: c_reg_w];
    assign out_rd_data = w_rd_entry[c_off_rd_data +: XLEN];
    assign out_cycle   = w_rd_entry[c_off_cycle   +: CYC_W];
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign triggered   = r_triggered;
    assign done        = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_capture
// Purpose  : Scoreboard bench for trace_capture against a queue-based model
// Revision : 1.0
// ============================================================================
module tb_trace_capture;

    localparam int XLEN      = 32;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 3;
    localparam int CYC_W     = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [15:0] cyc;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        capture_en;
    logic        mode;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_rd_we;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_rd_we;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_data;
    logic [15:0] out_cycle;
    logic [4:0]  count;
    logic        overflow;
    logic        triggered;
    logic        done;

    trace_capture #(
        .XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .capture_en(capture_en),
        .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_rd_we(in_rd_we), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_rd_we(out_rd_we), .out_rd_addr(out_rd_addr),
        .out_rd_data(out_rd_data), .out_cycle(out_cycle), .count(count),
        .overflow(overflow), .triggered(triggered), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t sb[$];
    ent_t mon_e;

    // Model state: 0 idle, 1 armed, 2 post-trigger, 3 done
    int   m_st   = 0;
    bit   m_ovf  = 0;
    bit   m_trig = 0;
    int   m_post = 0;
    logic [15:0] tb_cyc;

    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 16'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected: actual pc %0h, expected no entry", out_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("pop_pc",      {32'd0, out_pc},      {32'd0, mon_e.pc});
                chk("pop_inst",    {32'd0, out_inst},    {32'd0, mon_e.inst});
                chk("pop_rd_we",   {63'd0, out_rd_we},   {63'd0, mon_e.we});
                chk("pop_rd_addr", {59'd0, out_rd_addr}, {59'd0, mon_e.addr});
                chk("pop_rd_data", {32'd0, out_rd_data}, {32'd0, mon_e.data});
                chk("pop_cycle",   {48'd0, out_cycle},   {48'd0, mon_e.cyc});
            end
        end
    end

    task automatic model_reset();
        sb.delete();
        m_st = 0; m_ovf = 0; m_trig = 0; m_post = 0;
    endtask

    // Applies one clock of stimulus and advances the reference model to match
    task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit clr);
        ent_t e;
        int   orig;
        bit   pop;
        bit   full;
        e.pc   = pc;
        e.inst = $urandom;
        e.we   = 1'($urandom_range(0, 1));
        e.addr = 5'($urandom_range(0, 31));
        e.data = $urandom;
        e.cyc  = tb_cyc;
        in_valid = v; in_pc = e.pc; in_inst = e.inst; in_rd_we = e.we;
        in_rd_addr = e.addr; in_rd_data = e.data;
        clear     = clr;
        out_ready = clr ? 1'b0 : rdy;
        orig = m_st;
        pop  = out_ready && (sb.size() > 0);
        full = (sb.size() >= DEPTH);
        if (clr) begin
            model_reset();
        end else begin
            if ((orig == 1 || orig == 2) && v) begin
                if (full && !pop && !mode) begin
                    m_ovf = 1;
                    m_st  = 3;
                end else begin
                    if (full && !pop) begin
                        void'(sb.pop_front());
                        m_ovf = 1;
                    end
                    sb.push_back(e);
                    if (orig == 1 && trig_en && pc == trig_pc) begin
                        m_trig = 1;
                        m_post = POST_TRIG;
                        m_st   = (POST_TRIG == 0) ? 3 : 2;
                    end else if (orig == 2) begin
                        m_post--;
                        if (m_post == 0) m_st = 3;
                    end
                end
            end
            if (orig == 0 && capture_en) m_st = 1;
            else if ((orig == 1 || orig == 2) && !capture_en) m_st = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) drive(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; clear = 1'b0; capture_en = 1'b0; mode = 1'b1;
        trig_en = 1'b0; trig_pc = '0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        in_rd_we = 1'b0; in_rd_addr = '0; in_rd_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count",     64'(count),     64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_overflow",  64'(overflow),  64'd0);
        chk("reset_triggered", 64'(triggered), 64'd0);
        chk("reset_done",      64'(done),      64'd0);
        reset = 1'b1;

        // Basic capture and in-order drain
        capture_en = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
        chk("basic_count", 64'(count), 64'd5);
        chk("basic_head",  64'(out_pc), 64'd0);
        drain(5);
        chk("basic_drained", 64'(count), 64'd0);
        chk("basic_valid",   64'(out_valid), 64'd0);

        // Ring overflow keeps the newest DEPTH entries
        for (int i = 0; i < 20; i++) drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
        chk("ring_count",    64'(count), 64'd16);
        chk("ring_overflow", 64'(overflow), 64'd1);
        chk("ring_head",     64'(out_pc), 64'd16);
        drain(16);
        chk("ring_drained", 64'(count), 64'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        chk("clear_overflow", 64'(overflow), 64'd0);

        // Full buffer with simultaneous push and pop
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, 32'(32'h200 + 4 * i), 1'b0, 1'b0);
        drive(1'b1, 32'h300, 1'b1, 1'b0);
        chk("fullpp_count",    64'(count), 64'd16);
        chk("fullpp_overflow", 64'(overflow), 64'd0);

        // Clear wins over a push; the following cycle is IDLE so a push is ignored
        drive(1'b1, 32'h304, 1'b1, 1'b1);
        chk("clear_count", 64'(count), 64'd0);
        chk("clear_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 32'h308, 1'b0, 1'b0);
        chk("idle_ignored", 64'(count), 64'd0);

        // Empty buffer with simultaneous push and pop
        drive(1'b1, 32'h30C, 1'b1, 1'b0);
        chk("emptypp_count", 64'(count), 64'd1);
        drain(1);

        // Randomized ring-mode traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom & 32'hFFFF_FFFC),
                  1'($urandom_range(0, 1)), 1'b0);
            chk("rand_count",    64'(count), 64'(sb.size()));
            chk("rand_overflow", 64'(overflow), 64'(m_ovf));
        end
        drain(DEPTH);
        chk("rand_drained", 64'(count), 64'd0);

        // Stop-on-full
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        mode = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) drive(1'b1, 32'(32'h1000 + 4 * i), 1'b0, 1'b0);
        chk("sof_count",    64'(count), 64'd16);
        chk("sof_overflow", 64'(overflow), 64'd1);
        chk("sof_done",     64'(done), 64'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'(32'h2000 + 4 * i), 1'b0, 1'b0);
        chk("sof_ignored", 64'(count), 64'd16);
        drain(16);
        chk("sof_done_kept", 64'(done), 64'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        chk("sof_cleared", 64'(done), 64'd0);

        // Trigger window: 0x40 triggers, three more entries, then stop
        trig_en = 1'b1;
        trig_pc = 32'h40;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'(32'h30 + 4 * i), 1'b0, 1'b0);
            chk("trig_triggered", 64'(triggered), 64'((32'h30 + 4 * i) >= 32'h40));
            chk("trig_done",      64'(done),      64'((32'h30 + 4 * i) >= 32'h4C));
            chk("trig_count",     64'(count),     64'((i + 1) < 8 ? (i + 1) : 8));
        end
        drain(8);
        chk("trig_drained", 64'(count), 64'd0);

        // Asynchronous reset in the post-trigger window
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        mode = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(32'h38 + 4 * i), 1'b0, 1'b0);
        chk("post_triggered", 64'(triggered), 64'd1);
        chk("post_not_done",  64'(done), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_count",     64'(count), 64'd0);
        chk("areset_valid",     64'(out_valid), 64'd0);
        chk("areset_triggered", 64'(triggered), 64'd0);
        chk("areset_overflow",  64'(overflow), 64'd0);
        chk("areset_done",      64'(done), 64'd0);
        model_reset();
        #2;
        reset = 1'b1;
        // First edge arms (stamp 0), the push lands on the second edge with stamp 1
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        chk("restart_count", 64'(count), 64'd1);
        chk("restart_cycle", 64'(out_cycle), 64'd1);
        drain(1);
        chk("final_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trace_capture.md
# trace_capture

Synthesizable execution-trace recorder for the RISC-V core that replaces per-cycle `$monitor` logging. It snoops the core's retire stream: pc, instruction, and register write-back. Entries are stored with a cycle stamp in a parametrised circular buffer, with optional PC-match trigger and post-trigger window. Buffered entries are drained through a valid/ready port to a debug/UART bridge or bench.

## Interface
- `XLEN`, 32, data/pc width
- `DEPTH`, 16, buffer entries; power of two, ≥2
- `POST_TRIG`, 8, entries captured after the trigger entry; 0..DEPTH-1
- `CYC_W`, 16, cycle-stamp width; wraps modulo 2^CYC_W
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `clear` in 1: synchronous flush
- `capture_en` in 1: arm capture
- `mode` in 1: 0 = stop-on-full, 1 = ring (overwrite oldest)
- `trig_en` in 1: enable PC trigger
- `trig_pc` in XLEN: trigger address
- `in_valid` in 1: retire-stream entry present this cycle
- `in_pc` in XLEN: retire-stream pc
- `in_inst` in 32: retire-stream instruction
- `in_rd_we` in 1: retire-stream write-back enable
- `in_rd_addr` in 5: retire-stream destination register
- `in_rd_data` in XLEN: retire-stream write-back value
- `out_valid` out 1: head entry available
- `out_ready` in 1: consumer accepts head entry
- `out_pc` out XLEN: head-entry pc
- `out_inst` out 32: head-entry instruction
- `out_rd_we` out 1: head-entry write-back enable
- `out_rd_addr` out 5: head-entry destination register
- `out_rd_data` out XLEN: head-entry write-back value
- `out_cycle` out CYC_W: head-entry cycle stamp
- `count` out clog2(DEPTH)+1: occupancy
- `overflow` out 1: sticky
- `triggered` out 1: sticky
- `done` out 1: state == DONE

## Operation
- States: IDLE, ARMED, POST, DONE.
  - IDLE→ARMED when `capture_en`=1.
  - ARMED/POST→IDLE when `capture_en`=0; contents retained.
  - DONE→IDLE only on `clear`.
- Push: `in_valid`=1 in ARMED or POST writes {pc, inst, rd_we, rd_addr, rd_data, cycle_ctr} at wr_ptr. `in_*` are ignored in IDLE and DONE.
- Cycle counter:
  - Free-running from reset, +1 per clock, wraps.
  - Not cleared by `clear`.
- Trigger:
  - Applies in ARMED with `trig_en`=1 when an accepted entry has `in_pc`==`trig_pc`.
  - That entry is stored, `triggered` is set, and post_cnt is loaded with POST_TRIG.
  - POST_TRIG=0 → DONE; otherwise → POST.
  - In POST, each push decrements post_cnt; the push that brings it to 0 → DONE.
  - `trig_en`=0: ARMED captures indefinitely.
- Pop: `out_valid`=`(count!=0)`, in any state. `out_valid`&&`out_ready` advances rd_ptr.
- Full (`count`==DEPTH) with push and no pop:
  - mode 0: entry dropped, `overflow` set, → DONE.
  - mode 1: oldest overwritten, rd_ptr+1, `count` stays DEPTH, `overflow` set.
- Full with simultaneous push and pop: head is popped, new entry written, `count` stays DEPTH, no overflow, both modes.
- Empty with push and pop in the same cycle: pop is ignored (`out_valid`=0); push completes.
- Pointers are clog2(DEPTH) bits and wrap naturally.
- `clear`:
  - Takes priority over push/pop that cycle.
  - Pointers and `count`=0, `overflow`/`triggered`=0, post_cnt=0, state IDLE.
- Reset mid-operation: everything returns to reset values immediately. Buffer contents are lost logically; the storage array itself is not reset.

## Timing
- Reset values: `out_valid`=0, `count`=0, `overflow`=0, `triggered`=0, `done`=0, state IDLE, pointers 0, cycle_ctr 0. `out_*` data fields read entry 0 and are don't-care while `out_valid`=0.
- Push latency:
  - Entry written on the edge where accepted.
  - `count` and `out_valid` update on that same edge, so visible the following cycle.
- `out_*` are combinational reads of the array at rd_ptr (first-word fall-through).
- `out_*` hold stable while `out_valid`=1 and `out_ready`=0.
- State, `done` and `triggered` update on the edge of the triggering or terminating push.
- Throughput: one push and one pop per cycle sustained.

## Structure
- Package `trace_pkg` holds:
  - state encodings: IDLE=0, ARMED=1, POST=2, DONE=3
  - entry field offsets
  - entry width: XLEN+32+1+5+XLEN+CYC_W
- Sub-module `trace_ram`: DEPTH × entry-width flop array, one synchronous write port, one asynchronous read port, no reset.
- Control, pointers, counters and FSM live in `trace_capture`.

## Test plan
- Basic capture: reset, mode=1, trig_en=0, `capture_en`=1, 5 pushes pc=0,4,8,12,16, `out_ready`=0. Expect `count`=5, head pc=0. Then `out_ready`=1: 5 pops in order, `count`=0, `out_valid`=0.
- Ring overflow: DEPTH=16, mode=1, 20 pushes pc=4·i, no pops. Expect `count`=16, `overflow`=1, pops yield pc=16..76.
- Stop-on-full: mode=0, 17 pushes. Expect `count`=16, `overflow`=1, `done`=1, entry 17 absent, later `in_valid` ignored.
- Trigger window: trig_pc=0x40, POST_TRIG=3, pushes pc=0x30,0x34,…. Expect `triggered` on the edge pushing 0x40, `done` on the edge pushing 0x4C, `count`=8 (0x30..0x4C), and pc=0x50 not stored.
- Simultaneous events:
  - Full buffer, push+pop same cycle: `count` stays 16, `overflow`=0.
  - Empty buffer, push+pop same cycle: `count`=1.
  - `clear` during push: `count`=0, state IDLE.
- Async reset mid-POST: assert `reset`=0 between edges. Outputs go to reset values without a clock edge; capture restarts cleanly after deassert and `out_cycle` restarts from 0.
